// File: rtl/commit_trace_monitor.sv
// Commit-trace monitor: keeps the last DEPTH commits in a ring buffer, detects halt
// conditions, latches a cause code and drains the trace oldest-first over a valid/ready port.
module commit_trace_monitor #(
   parameter int unsigned     XLEN        = 64,
   parameter int unsigned     LANES       = 2,
   parameter int unsigned     DEPTH       = 16,
   parameter logic [XLEN-1:0] PC_LO       = 64'h3000_0000,
   parameter int unsigned     WDOG_CYCLES = 4096,
   parameter int unsigned     CYCLE_LIMIT = 400000000,
   parameter int unsigned     HEARTBEAT   = 32'h300000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [LANES-1:0]      commit_valid,
   input  logic [LANES*XLEN-1:0] commit_pc,
   input  logic [LANES*XLEN-1:0] commit_wdata,
   input  logic                  cpu_ebreak_sign,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [XLEN-1:0]       dump_pc,
   output logic [XLEN-1:0]       dump_wdata,
   output logic                  dump_last,
   output logic                  halt,
   output logic [2:0]            halt_cause,
   output logic                  heartbeat,
   output logic [63:0]           commit_count,
   output logic [31:0]           cycle_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   cnt_t;
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   ptr_t            wr_ptr_q, wr_ptr_d;
   cnt_t            count_q, count_d;
   logic [XLEN-1:0] mem_pc_q [DEPTH];
   logic [XLEN-1:0] mem_pc_d [DEPTH];
   logic [XLEN-1:0] mem_wd_q [DEPTH];
   logic [XLEN-1:0] mem_wd_d [DEPTH];
   logic [63:0]     commit_count_q, commit_count_d;
   logic [31:0]     cycle_count_q, cycle_count_d;
   logic [31:0]     idle_q, idle_d;
   logic [31:0]     hb_q, hb_d;
   logic            heartbeat_q, heartbeat_d;
   logic            halt_q, halt_d;
   logic [2:0]      cause_q, cause_d;

   ptr_t            widx;
   ptr_t            rd_idx;
   cnt_t            pop;
   logic [AW+1:0]   occ_sum;
   logic            bad_pc;
   logic            hb_wrap;
   logic [2:0]      cause;

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      count_d        = count_q;
      mem_pc_d       = mem_pc_q;
      mem_wd_d       = mem_wd_q;
      commit_count_d = commit_count_q;
      cycle_count_d  = cycle_count_q;
      idle_d         = idle_q;
      hb_d           = hb_q;
      heartbeat_d    = 1'b0;
      halt_d         = halt_q;
      cause_d        = cause_q;
      widx           = wr_ptr_q;
      pop            = '0;
      occ_sum        = '0;
      bad_pc         = 1'b0;
      hb_wrap        = 1'b0;
      cause          = 3'd0;
      // Oldest entry sits count_q slots behind the write pointer; a full buffer wraps to wr_ptr.
      rd_idx         = wr_ptr_q - count_q[AW-1:0];

      if (state_q == S_RUN) begin
         // Valid lanes are packed in lane order so skipped lanes leave no hole.
         for (int unsigned i = 0; i < LANES; i++) begin
            if (commit_valid[i]) begin
               mem_pc_d[widx] = commit_pc[i*XLEN +: XLEN];
               mem_wd_d[widx] = commit_wdata[i*XLEN +: XLEN];
               widx           = widx + 1'b1;
               pop            = pop + 1'b1;
               if (commit_pc[i*XLEN +: XLEN] < PC_LO) bad_pc = 1'b1;
            end
         end
         wr_ptr_d       = widx;
         occ_sum        = {1'b0, count_q} + {1'b0, pop};
         count_d        = (occ_sum > (AW+2)'(DEPTH)) ? cnt_t'(DEPTH) : occ_sum[AW:0];
         commit_count_d = commit_count_q + 64'(pop);
         cycle_count_d  = cycle_count_q + 32'd1;
         idle_d         = (|commit_valid) ? 32'd0 : idle_q + 32'd1;
         hb_wrap        = (hb_q == 32'(HEARTBEAT - 1));
         hb_d           = hb_wrap ? 32'd0 : hb_q + 32'd1;

         if (cpu_ebreak_sign)                                          cause = 3'd1;
         else if (bad_pc)                                              cause = 3'd2;
         else if (idle_q == 32'(WDOG_CYCLES - 1) && !(|commit_valid))  cause = 3'd3;
         else if (cycle_count_q == 32'(CYCLE_LIMIT - 1))               cause = 3'd4;

         if (cause != 3'd0) begin
            halt_d  = 1'b1;
            cause_d = cause;
            state_d = (count_d != '0) ? S_DRAIN : S_DONE;
         end
         // The pulse is suppressed when the next cycle is no longer RUN.
         heartbeat_d = hb_wrap && (cause == 3'd0);
      end else if (state_q == S_DRAIN) begin
         if (dump_ready) begin
            count_d = count_q - 1'b1;
            if (count_q == cnt_t'(1)) state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_RUN;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         commit_count_q <= '0;
         cycle_count_q  <= '0;
         idle_q         <= '0;
         hb_q           <= '0;
         heartbeat_q    <= 1'b0;
         halt_q         <= 1'b0;
         cause_q        <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         commit_count_q <= commit_count_d;
         cycle_count_q  <= cycle_count_d;
         idle_q         <= idle_d;
         hb_q           <= hb_d;
         heartbeat_q    <= heartbeat_d;
         halt_q         <= halt_d;
         cause_q        <= cause_d;
      end
   end

   // Trace storage needs no reset: the dump outputs are gated by state.
   always_ff @(posedge clock) begin
      mem_pc_q <= mem_pc_d;
      mem_wd_q <= mem_wd_d;
   end

   assign dump_valid   = (state_q == S_DRAIN);
   assign dump_pc      = dump_valid ? mem_pc_q[rd_idx] : '0;
   assign dump_wdata   = dump_valid ? mem_wd_q[rd_idx] : '0;
   assign dump_last    = dump_valid && (count_q == cnt_t'(1));
   assign halt         = halt_q;
   assign halt_cause   = cause_q;
   assign heartbeat    = heartbeat_q;
   assign commit_count = commit_count_q;
   assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Scoreboard bench for commit_trace_monitor: directed scenarios push expected dump
// entries; a negedge monitor pops and compares each transferred entry.
module tb_commit_trace_monitor;

   logic         clock;
   logic         reset;
   logic [1:0]   commit_valid;
   logic [127:0] commit_pc;
   logic [127:0] commit_wdata;
   logic         cpu_ebreak_sign;
   logic         dump_valid;
   logic         dump_ready;
   logic [63:0]  dump_pc;
   logic [63:0]  dump_wdata;
   logic         dump_last;
   logic         halt;
   logic [2:0]   halt_cause;
   logic         heartbeat;
   logic [63:0]  commit_count;
   logic [31:0]  cycle_count;

   commit_trace_monitor #(
      .XLEN(64), .LANES(2), .DEPTH(4), .PC_LO(64'h3000_0000),
      .WDOG_CYCLES(8), .CYCLE_LIMIT(100), .HEARTBEAT(10)
   ) dut (
      .clock(clock), .reset(reset), .commit_valid(commit_valid),
      .commit_pc(commit_pc), .commit_wdata(commit_wdata),
      .cpu_ebreak_sign(cpu_ebreak_sign), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_pc(dump_pc), .dump_wdata(dump_wdata),
      .dump_last(dump_last), .halt(halt), .halt_cause(halt_cause),
      .heartbeat(heartbeat), .commit_count(commit_count), .cycle_count(cycle_count)
   );

   typedef struct {
      logic [63:0] pc;
      logic [63:0] wd;
      logic        last;
   } ent_t;

   ent_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   xfers = 0;
   logic        held = 1'b0;
   logic [63:0] held_pc, held_wd;
   logic        held_last;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [63:0] pc, input logic [63:0] wd, input logic last);
      ent_t e;
      e.pc = pc; e.wd = wd; e.last = last;
      sb.push_back(e);
   endtask

   task automatic lanes(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1);
      commit_valid = v;
      commit_pc    = {p1, p0};
      commit_wdata = {p1 + 64'd1, p0 + 64'd1};
   endtask

   task automatic idle_inputs();
      commit_valid    = '0;
      commit_pc       = '0;
      commit_wdata    = '0;
      cpu_ebreak_sign = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      dump_ready = 1'b1;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      sb.delete();
      xfers = 0;
   endtask

   // Wait for the scoreboard to empty and dump_valid to drop, optionally toggling ready.
   task automatic wait_drain(input string name, input bit toggle);
      int unsigned n = 0;
      while ((sb.size() != 0 || dump_valid) && n < 40) begin
         if (toggle) dump_ready = ~dump_ready;
         step();
         n++;
      end
      chk({name, "_drain_done"}, 64'(n < 40), 64'd1);
      dump_ready = 1'b1;
   endtask

   // Monitor: compares each transferred entry and checks stability under backpressure.
   always @(negedge clock) begin
      if (!reset && dump_valid) begin
         if (held) begin
            chk("hold_pc", dump_pc, held_pc);
            chk("hold_wdata", dump_wdata, held_wd);
            chk("hold_last", 64'(dump_last), 64'(held_last));
         end
         if (dump_ready) begin
            held = 1'b0;
            xfers++;
            if (sb.size() == 0) begin
               chk("unexpected_dump", dump_pc, 64'd0);
               chk("unexpected_dump_valid", 64'(dump_valid), 64'd0);
            end else begin
               ent_t e;
               e = sb.pop_front();
               chk("dump_pc", dump_pc, e.pc);
               chk("dump_wdata", dump_wdata, e.wd);
               chk("dump_last", 64'(dump_last), 64'(e.last));
            end
         end else begin
            held      = 1'b1;
            held_pc   = dump_pc;
            held_wd   = dump_wdata;
            held_last = dump_last;
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      dump_ready = 1'b1;
      idle_inputs();

      // Dual-lane overwrite then ebreak drain
      do_reset();
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_cause", 64'(halt_cause), 64'd0);
      chk("rst_dump_valid", 64'(dump_valid), 64'd0);
      chk("rst_dump_pc", dump_pc, 64'd0);
      chk("rst_commit_count", commit_count, 64'd0);
      chk("rst_cycle_count", 64'(cycle_count), 64'd0);
      chk("rst_heartbeat", 64'(heartbeat), 64'd0);
      lanes(2'b11, 64'h8000_0000, 64'h8000_0004); step();
      lanes(2'b11, 64'h8000_0008, 64'h8000_000C); step();
      chk("t1_no_halt", 64'(halt), 64'd0);
      lanes(2'b11, 64'h8000_0010, 64'h8000_0014); step();
      idle_inputs();
      cpu_ebreak_sign = 1'b1;
      push(64'h8000_0008, 64'h8000_0009, 1'b0);
      push(64'h8000_000C, 64'h8000_000D, 1'b0);
      push(64'h8000_0010, 64'h8000_0011, 1'b0);
      push(64'h8000_0014, 64'h8000_0015, 1'b1);
      step();
      cpu_ebreak_sign = 1'b0;
      chk("t1_halt", 64'(halt), 64'd1);
      chk("t1_cause", 64'(halt_cause), 64'd1);
      chk("t1_dump_valid", 64'(dump_valid), 64'd1);
      chk("t1_commit_count", commit_count, 64'd6);
      chk("t1_cycle_count", 64'(cycle_count), 64'd4);
      wait_drain("t1", 1'b0);
      chk("t1_xfers", 64'(xfers), 64'd4);
      chk("t1_halt_sticky", 64'(halt), 64'd1);

      // Bad pc on lane 1
      do_reset();
      lanes(2'b11, 64'h8000_0000, 64'h2FFF_FFFC);
      push(64'h8000_0000, 64'h8000_0001, 1'b0);
      push(64'h2FFF_FFFC, 64'h2FFF_FFFD, 1'b1);
      step();
      idle_inputs();
      chk("t2_halt", 64'(halt), 64'd1);
      chk("t2_cause", 64'(halt_cause), 64'd2);
      chk("t2_commit_count", commit_count, 64'd2);
      wait_drain("t2", 1'b0);

      // Simultaneous ebreak and bad pc
      do_reset();
      lanes(2'b01, 64'h10, 64'h0);
      cpu_ebreak_sign = 1'b1;
      push(64'h10, 64'h11, 1'b1);
      step();
      idle_inputs();
      chk("t3_cause", 64'(halt_cause), 64'd1);
      wait_drain("t3", 1'b0);

      // Watchdog on an empty buffer
      do_reset();
      repeat (7) step();
      chk("t4_no_halt_7", 64'(halt), 64'd0);
      step();
      chk("t4_halt", 64'(halt), 64'd1);
      chk("t4_cause", 64'(halt_cause), 64'd3);
      chk("t4_dump_valid", 64'(dump_valid), 64'd0);
      repeat (3) step();
      chk("t4_dump_valid_later", 64'(dump_valid), 64'd0);
      chk("t4_cycle_count", 64'(cycle_count), 64'd8);

      // Backpressure with a lane-1-only and lane-0-only cycle
      do_reset();
      lanes(2'b11, 64'h9000_0000, 64'h9000_0004); step();
      lanes(2'b10, 64'h0, 64'h9000_0008); step();
      lanes(2'b01, 64'h9000_000C, 64'h0); step();
      idle_inputs();
      cpu_ebreak_sign = 1'b1;
      dump_ready = 1'b0;
      push(64'h9000_0000, 64'h9000_0001, 1'b0);
      push(64'h9000_0004, 64'h9000_0005, 1'b0);
      push(64'h9000_0008, 64'h9000_0009, 1'b0);
      push(64'h9000_000C, 64'h9000_000D, 1'b1);
      step();
      cpu_ebreak_sign = 1'b0;
      chk("t5_commit_count", commit_count, 64'd4);
      dump_ready = 1'b0;
      step();
      chk("t5_still_valid", 64'(dump_valid), 64'd1);
      wait_drain("t5", 1'b1);
      chk("t5_xfers", 64'(xfers), 64'd4);

      // Same sequence, reset after two transfers
      do_reset();
      lanes(2'b11, 64'h9000_0000, 64'h9000_0004); step();
      lanes(2'b11, 64'h9000_0008, 64'h9000_000C); step();
      idle_inputs();
      cpu_ebreak_sign = 1'b1;
      push(64'h9000_0000, 64'h9000_0001, 1'b0);
      push(64'h9000_0004, 64'h9000_0005, 1'b0);
      push(64'h9000_0008, 64'h9000_0009, 1'b0);
      push(64'h9000_000C, 64'h9000_000D, 1'b1);
      step();
      cpu_ebreak_sign = 1'b0;
      step();
      step();
      chk("t5b_xfers", 64'(xfers), 64'd2);
      dump_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb.delete();
      dump_ready = 1'b1;
      chk("t5b_dump_valid", 64'(dump_valid), 64'd0);
      chk("t5b_dump_last", 64'(dump_last), 64'd0);
      chk("t5b_dump_pc", dump_pc, 64'd0);
      chk("t5b_halt", 64'(halt), 64'd0);
      chk("t5b_cause", 64'(halt_cause), 64'd0);
      chk("t5b_commit_count", commit_count, 64'd0);
      lanes(2'b01, 64'h8000_0000, 64'h0);
      step();
      idle_inputs();
      chk("t5b_run_commit", commit_count, 64'd1);

      // Cycle limit and heartbeat
      do_reset();
      for (int k = 1; k <= 100; k++) begin
         lanes(2'b01, 64'h8000_0000 + 64'(4 * (k - 1)), 64'h0);
         if (k == 100) begin
            push(64'h8000_0180, 64'h8000_0181, 1'b0);
            push(64'h8000_0184, 64'h8000_0185, 1'b0);
            push(64'h8000_0188, 64'h8000_0189, 1'b0);
            push(64'h8000_018C, 64'h8000_018D, 1'b1);
         end
         step();
         chk($sformatf("t6_heartbeat_c%0d", k + 1), 64'(heartbeat),
             64'((((k + 1) % 10) == 1) && (k + 1) >= 11 && (k + 1) <= 91));
         if (k == 99) chk("t6_no_halt_c100", 64'(halt), 64'd0);
      end
      idle_inputs();
      chk("t6_halt", 64'(halt), 64'd1);
      chk("t6_cause", 64'(halt_cause), 64'd4);
      chk("t6_cycle_count", 64'(cycle_count), 64'd100);
      chk("t6_commit_count", commit_count, 64'd100);
      wait_drain("t6", 1'b0);
      chk("t6_cycle_frozen", 64'(cycle_count), 64'd100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/commit_trace_monitor.md
# commit_trace_monitor

Parametrised commit-trace monitor for the NPC core, the next generation of the simulation commit logger. It records the last DEPTH committed instructions (pc, write data) from up to LANES commit lanes into a ring buffer. It detects halt conditions: ebreak, PC below the legal floor, a commit watchdog and a cycle limit. On halt it latches a cause code and drains the buffered trace oldest-first over a valid/ready dump port. It is fully synthesizable, so the same block serves Verilator and FPGA bring-up.

## Interface
Parameters:
- XLEN, 64, pc/data width
- LANES, 2, commit lanes per cycle (1..4)
- DEPTH, 16, trace entries; power of two, >= LANES
- PC_LO, 64'h3000_0000, lowest legal commit pc
- WDOG_CYCLES, 4096, max consecutive cycles without a commit
- CYCLE_LIMIT, 400000000, max RUN cycles
- HEARTBEAT, 32'h300000, heartbeat period in cycles

Ports:
- clock  in  1  single clock; everything is on posedge
- reset  in  1  synchronous, active-high
- commit_valid  in  LANES  per-lane commit strobe
- commit_pc  in  LANES*XLEN  lane i at bits [i*XLEN +: XLEN]
- commit_wdata  in  LANES*XLEN  lane i write data
- cpu_ebreak_sign  in  1  ebreak retired this cycle
- dump_valid  out  1  trace entry available
- dump_ready  in  1  consumer accepts entry
- dump_pc  out  XLEN  entry pc
- dump_wdata  out  XLEN  entry write data
- dump_last  out  1  final entry of the drain
- halt  out  1  monitor has stopped; sticky until reset
- halt_cause  out  3  0 none, 1 ebreak, 2 bad pc, 3 watchdog, 4 cycle limit
- heartbeat  out  1  one-cycle pulse every HEARTBEAT RUN cycles
- commit_count  out  64  total commits recorded
- cycle_count  out  32  RUN cycles elapsed

## Operation
- States are RUN, DRAIN and DONE. Reset enters RUN with all outputs 0, the buffer empty and all counters 0.
- RUN capture:
  - Each valid lane is written in lane order; lane 0 is the oldest. Invalid lanes are skipped and leave no hole.
  - Writes per cycle equal popcount(commit_valid).
  - When the buffer is full, the oldest entries are overwritten. The occupancy count saturates at DEPTH.
  - commit_count increments by popcount each cycle.
- Trigger conditions, evaluated in RUN on the current cycle's inputs:
  - ebreak: cpu_ebreak_sign = 1.
  - bad pc: any valid lane has commit_pc < PC_LO (unsigned compare).
  - watchdog: the idle counter equals WDOG_CYCLES-1 and no lane is valid.
  - cycle limit: cycle_count equals CYCLE_LIMIT-1.
- Priority when several triggers fire together: ebreak > bad pc > watchdog > cycle limit.
- The commits of the trigger cycle, including an offending bad pc, are still recorded.
- Idle counter: cleared in any cycle with a valid lane, otherwise incremented. It is internal.
- On trigger:
  - halt_cause is latched.
  - The next state is DRAIN if occupancy after this cycle's writes is > 0, else DONE.
- DRAIN:
  - dump_valid = 1 and the oldest entry is presented.
  - An entry transfers when dump_valid & dump_ready; the read pointer then advances and occupancy decrements.
  - dump_last = 1 while occupancy = 1.
  - After the last transfer the state goes to DONE.
  - dump_pc, dump_wdata and dump_last hold stable while valid & !ready.
- In DRAIN and DONE, commits and ebreak are ignored, and all counters freeze.
- DONE: dump_valid = 0; halt and halt_cause hold until reset.
- Reset in any state, including mid-drain, returns to RUN with an empty buffer and cause 0.
- heartbeat:
  - An internal counter wraps at HEARTBEAT-1.
  - heartbeat is a registered pulse in the cycle after each wrap.
  - It pulses only in RUN.

## Timing
- A commit that is valid in cycle N is visible in the buffer from cycle N+1.
- Trigger in cycle N gives halt = 1, a valid halt_cause and, if non-empty, dump_valid = 1, all from cycle N+1.
- Drain throughput is one entry per cycle while dump_ready = 1. There is no bubble between entries.
- In DRAIN, halt rises together with the first dump_valid.
- cycle_count increments once per RUN cycle, including the trigger cycle.
- No combinational path from commit_* or cpu_ebreak_sign to any output. dump_* depend only on state and buffer registers.

## Test plan
Bench parameters: LANES=2, DEPTH=4, PC_LO=64'h3000_0000, WDOG_CYCLES=8, CYCLE_LIMIT=100, HEARTBEAT=10.
- Dual-lane overwrite and ebreak drain:
  - Stimulus: 3 cycles with both lanes valid, pcs 0x80000000..0x80000014 step 4, wdata = pc+1. Then cpu_ebreak_sign = 1 with no commits. dump_ready held 1.
  - Required: halt and cause 1 at the next cycle. Dump order is pcs 0x80000008, 0x8000000C, 0x80000010, 0x80000014. dump_last is asserted only on 0x80000014. commit_count = 6.
- Bad pc on lane 1:
  - Stimulus: lane 0 pc 0x80000000 and lane 1 pc 0x2FFFFFFC in the same cycle, with cpu_ebreak_sign = 0.
  - Required: cause 2. Dump gives 0x80000000 then 0x2FFFFFFC with last.
- Simultaneous triggers:
  - Stimulus: cpu_ebreak_sign = 1 together with a lane-0 pc of 0x10.
  - Required: cause 1 (ebreak wins). The bad-pc entry is still dumped.
- Watchdog on an empty buffer:
  - Stimulus: no commits after reset.
  - Required: halt with cause 3 on the cycle after the 8th idle cycle. dump_valid never asserts. State goes directly to DONE.
- Backpressure then mid-drain reset:
  - Stimulus: 4 entries buffered, then ebreak. dump_ready toggles 0/1.
  - Required: the entry holds stable while ready = 0, and 4 transfers complete.
  - Follow-up: repeat the sequence and assert reset after 2 transfers. Outputs go to 0 the next cycle and the state is RUN.
- Cycle limit and heartbeat:
  - Stimulus: one lane-0 commit every cycle at a legal pc.
  - Required: heartbeat pulses at cycles 11, 21, …, 91. Cause 4 is latched with halt = 1 at cycle 101. cycle_count = 100.
